// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Contents: stall-vector bit positions, stall patterns and the controller FSM state type.
package pipe_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    typedef logic [STALL_W-1:0] stall_t;

    // A load-use hazard freezes PC, IF_ID and ID_EX.
    // A multi-cycle EX op additionally freezes EX_MEM.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic {
        IDLE,
        EX_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall/flush controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic [CNT_W-1:0]  ex_cycles;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, ex_cycles, branch_flag, branch_target,
        input  stall, flush, new_pc, busy, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_cycles, branch_flag, branch_target,
        output stall, flush, new_pc, busy, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Enable-gated up-counter that sticks at all-ones.
// The counter clears asynchronously on reset.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i && !(&count_q)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Contains the EX multi-cycle FSM, the stall down-counter and the stall perf counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave ctrl
);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ex_len;
    stall_t            stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic [PERF_W-1:0] perf_cnt;

    // A zero-length request still costs the request cycle itself.
    assign ex_len = (ctrl.ex_cycles == '0) ? CNT_W'(1) : ctrl.ex_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = '0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (ctrl.stallreq_ex) begin
                        stall = STALL_EX;
                        if (ex_len > CNT_W'(1)) begin
                            state_d = EX_WAIT;
                            cnt_d   = ex_len - CNT_W'(1);
                        end
                    end else if (ctrl.branch_flag) begin
                        flush  = 1'b1;
                        new_pc = ctrl.branch_target;
                    end else if (ctrl.stallreq_id) begin
                        stall = STALL_ID;
                    end
                end
                EX_WAIT: begin
                    // ID is frozen here; any branch or hazard it holds is re-raised after release.
                    stall = STALL_EX;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sat_cnt #(.W(PERF_W)) u_stall_perf (
        .clk     (clk),
        .rst     (rst),
        .en_i    (stall != STALL_NONE),
        .count_o (perf_cnt)
    );

    assign ctrl.stall        = stall;
    assign ctrl.flush        = flush;
    assign ctrl.new_pc       = new_pc;
    assign ctrl.busy         = (state_q == EX_WAIT);
    assign ctrl.stall_cycles = perf_cnt;

    a_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
        (state_q == EX_WAIT) |-> (cnt_q != '0));

    a_flush_excl: assert property (@(posedge clk) disable iff (rst)
        !(flush && (stall[STALL_IFID] || stall[STALL_PC])));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven cycle vectors with a scoreboard queue,
// plus a hand-written asynchronous reset pulse in the middle of an EX stall.
module tb_pipe_ctrl;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam int PERF_W = 16;

    typedef struct {
        logic        rst;
        logic        id;
        logic        ex;
        logic [3:0]  exc;
        logic        br;
        logic [15:0] tgt;
        logic [5:0]  stall;
        logic        flush;
        logic [15:0] npc;
        logic        busy;
        logic [15:0] perf;
    } vec_t;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t tail[$];
    vec_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic id, input logic ex, input logic [3:0] c,
                                input logic br, input logic [15:0] t, input logic [5:0] s,
                                input logic f, input logic [15:0] np, input logic b,
                                input logic [15:0] p);
        vec_t v;
        v.rst = r;  v.id = id; v.ex = ex; v.exc = c; v.br = br; v.tgt = t;
        v.stall = s; v.flush = f; v.npc = np; v.busy = b; v.perf = p;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.stallreq_id   = v.id;
        bus.stallreq_ex   = v.ex;
        bus.ex_cycles     = v.exc;
        bus.branch_flag   = v.br;
        bus.branch_target = v.tgt;
    endtask

    // Drive one cycle's inputs, queue its expectation, compare at the falling edge.
    task automatic apply_vec(input vec_t v, input string tag);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".stall"}, 32'(bus.stall),        32'(e.stall));
        check({tag, ".flush"}, 32'(bus.flush),        32'(e.flush));
        check({tag, ".new_pc"}, 32'(bus.new_pc),      32'(e.npc));
        check({tag, ".busy"},  32'(bus.busy),         32'(e.busy));
        check({tag, ".perf"},  32'(bus.stall_cycles), 32'(e.perf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with every request high
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 16'h0040, 6'h00, 0, 16'h0000, 0, 16'd0));
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 16'h0040, 6'h00, 0, 16'h0000, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd0));
        // load-use stall for one cycle
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0000, 6'h07, 0, 16'h0000, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd1));
        // four-cycle EX op; requests during EX_WAIT are ignored
        vecs.push_back(mk(0, 0, 1, 4'd4, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd1));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 1, 16'd2));
        vecs.push_back(mk(0, 0, 1, 4'd9, 1, 16'h1234, 6'h0F, 0, 16'h0000, 1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 1, 16'd4));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd5));
        // branch redirect, then branch dropped under an EX request
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 16'h0040, 6'h00, 1, 16'h0040, 0, 16'd5));
        vecs.push_back(mk(0, 0, 1, 4'd1, 1, 16'h0040, 6'h0F, 0, 16'h0000, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd6));
        // ex_cycles of 0 and 1 each cost exactly one cycle
        vecs.push_back(mk(0, 0, 1, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd7));
        vecs.push_back(mk(0, 0, 1, 4'd1, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd7));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd8));
        // priority: EX over ID, branch over ID
        vecs.push_back(mk(0, 1, 1, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd8));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 16'hBEEF, 6'h00, 1, 16'hBEEF, 0, 16'd9));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd9));
        // maximum-length EX op: 15 stall cycles
        vecs.push_back(mk(0, 0, 1, 4'd15, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd9));
        for (int i = 1; i <= 14; i++)
            vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 1, 16'(9 + i)));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd24));
        // lead-in to a reset pulse while in EX_WAIT
        vecs.push_back(mk(0, 0, 1, 4'd4, 0, 16'h0000, 6'h0F, 0, 16'h0000, 0, 16'd24));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h0F, 0, 16'h0000, 1, 16'd25));

        // after reset release, a load-use stall behaves as from a clean start
        tail.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0000, 6'h07, 0, 16'h0000, 0, 16'd0));
        tail.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 6'h00, 0, 16'h0000, 0, 16'd1));

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

        // now in EX_WAIT with cnt=2; reset asynchronously between edges
        drive(mk(0, 1, 1, 4'd4, 1, 16'h0040, 6'h00, 0, 16'h0000, 0, 16'd0));
        check("pre_rst.busy",  32'(bus.busy), 32'd1);
        check("pre_rst.stall", 32'(bus.stall), 32'h0F);
        rst = 1'b1;
        #1;
        check("async_rst.stall", 32'(bus.stall),        32'h00);
        check("async_rst.busy",  32'(bus.busy),         32'd0);
        check("async_rst.flush", 32'(bus.flush),        32'd0);
        check("async_rst.perf",  32'(bus.stall_cycles), 32'd0);
        @(negedge clk);
        check("rst_hold.stall",  32'(bus.stall),        32'h00);
        check("rst_hold.new_pc", 32'(bus.new_pc),       32'h0000);
        @(posedge clk);
        #1;

        foreach (tail[i]) apply_vec(tail[i], $sformatf("t%0d", i));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
